bfp_to_fp: RTL and testbench
============================

# bfp_to_fp

Converts a block-floating-point dot-product result back to IEEE-754 format. Input is a signed fixed-point sum with a shared biased exponent; output is a packed float of width BIT. The block is the decode end of the float→BFP path: it sits after `vectProd` and accepts its `outVectProd` and `outExp`. Normalisation is iterative, one bit per cycle, under a small FSM with valid/ready handshakes on both sides.

## Interface
- V, 8: vector length; sets the guard width clog2(V).
- BIT, 32: float width.
- FPM, 23: float fraction bits.
- BFPM, 4: BFP mantissa fraction bits per operand.
- Derived widths and constants:
  - W = 2*(BFPM+2)+clog2(V): input width.
  - E = BIT-FPM-1: exponent width.
  - F = 2*BFPM: input fractional bits.
  - BIAS = 2^(E-1)-1.
- Ports (clock and reset first):
  - clk  in  1  clock.
  - reset  in  1  synchronous, active-high reset.
  - in_valid  in  1  in_val/in_exp valid.
  - in_ready  out  1  block can accept.
  - in_val  in  W  two's-complement sum; value = in_val·2^(in_exp−BIAS−F).
  - in_exp  in  E  shared biased exponent.
  - out_valid  out  1  out_fp valid.
  - out_ready  in  1  consumer accepts.
  - out_fp  out  BIT  IEEE-754 result.
  - out_flags  out  3  {ovf, unf, zero}.

## Operation
- States:
  - IDLE: in_ready=1.
  - NORM: shift magnitude left.
  - PACK: compute exponent and fraction.
  - OUT: result presented.
- IDLE, on in_valid&&in_ready:
  - Latch sign = in_val[W−1].
  - Latch mag = |in_val| as W-bit unsigned. The most negative input gives mag = 2^(W−1).
  - Set k = W−1 and latch in_exp.
  - Go to PACK if in_val==0, else to NORM.
- NORM: if mag[W−1]==1, go to PACK; else mag<<=1 and k−=1.
- PACK:
  - e = in_exp + k − F, computed signed with E+2 bits.
  - frac = mag[W−2:0], left-aligned into FPM bits. Bits are zero-filled if W−1<FPM and truncated otherwise, subject to the Configuration section.
  - Zero input: out_fp = all zero, zero=1.
  - e ≤ 0: out_fp = {sign, zeros}, unf=1. Flush to signed zero; no denormals.
  - e ≥ 2^E−1: out_fp = {sign, all-ones exponent, zero fraction}, ovf=1.
  - Otherwise: out_fp = {sign, e[E−1:0], frac}.
  - Go to OUT.
- OUT: out_valid=1. On out_ready, go to IDLE.
- Zero, unf and ovf are mutually exclusive.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_fp=0, out_flags=0. Internal registers are cleared.
- Let k be the leading-one index of the magnitude and s = W−1−k the shift count.
- Latency from the accept edge to out_valid high:
  - s+2 edges for nonzero input.
  - 1 edge for zero input.
- Default parameters give a maximum latency of W+1 = 16.
- in_ready=1 only in IDLE. There is one transaction in flight; no input is accepted until the OUT handshake completes.
- out_fp and out_flags are stable while out_valid=1 and out_ready=0.
- out_valid falls on the edge where out_valid&&out_ready. The next input can be accepted on the following edge; there is no same-cycle turnaround.
- in_val and in_exp are sampled only at the accept edge. Later changes are ignored.
- Reset asserted in any state returns the block to IDLE at the next edge and discards the in-flight result; out_valid=0 that cycle.

## Configuration
- Macro BFP2FP_RNE_EN controls rounding of bits dropped when W−1 > FPM.
- Defined: round-to-nearest-even on the dropped bits.
  - A mantissa carry-out increments e.
  - If the increment reaches 2^E−1, the result becomes infinity with ovf=1.
  - Rounding is performed inside PACK; latency is unchanged.
- Undefined: truncation (round toward zero).
- At default parameters W−1=14 < FPM, so output is identical with or without the macro.

## Test plan
Defaults apply unless stated: W=15, F=8, BIAS=127.

1. Basic conversions:
   - in_val=256, in_exp=127 → out_fp=0x3F800000, flags=0, out_valid 8 edges after accept.
   - in_val=−384, in_exp=128 → 0xC0400000.
2. Zero and most-negative input:
   - in_val=0, any in_exp → out_fp=0x00000000, flags=3'b001, latency 1.
   - in_val=−16384, in_exp=127 → 0xC2800000, latency 2.
3. Range limits:
   - in_val=16383, in_exp=250 → 0x7F800000, ovf.
   - in_val=1, in_exp=5 → 0x00000000, unf.
   - in_val=−1, in_exp=5 → 0x80000000, unf.
4. Backpressure: hold out_ready=0 for 10 cycles → out_fp and flags stable, in_ready=0, and a new in_valid is ignored. Then release → the next input is accepted on the edge after the handshake.
5. Reset mid-NORM: accept in_val=1, assert reset 3 cycles later → IDLE, out_valid=0, in_ready=1. The next transaction converts correctly.
6. Rounding, with BFPM=12 (W=31, F=24) and in_exp=127:
   - in_val=0x01000001 → 0x3F800000 with or without BFP2FP_RNE_EN.
   - in_val=0x01000003 → 0x3F800002 with the macro, 0x3F800001 without.

Source files
------------

// File: rtl/bfp_to_fp.sv
// bfp_to_fp: converts a block-floating-point dot-product result (signed fixed-point sum plus
// shared biased exponent) into a packed IEEE-754 float. Normalisation shifts one bit per cycle.
//
// Optional build macro: BFP2FP_RNE_EN
//   defined   -> round-to-nearest-even on fraction bits dropped when W-1 > FPM
//   undefined -> truncation (round toward zero)
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   in_valid   in_val/in_exp valid
//   in_ready   block can accept (IDLE only)
//   in_val     W-bit two's-complement sum, value = in_val * 2^(in_exp - BIAS - F)
//   in_exp     E-bit shared biased exponent
//   out_valid  out_fp/out_flags valid
//   out_ready  consumer accepts
//   out_fp     BIT-bit IEEE-754 result
//   out_flags  {ovf, unf, zero}
module bfp_to_fp #(
  parameter int unsigned V    = 8,
  parameter int unsigned BIT  = 32,
  parameter int unsigned FPM  = 23,
  parameter int unsigned BFPM = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [2*(BFPM+2)+$clog2(V)-1:0]        in_val,
  input  logic [BIT-FPM-2:0]                     in_exp,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [BIT-1:0]                         out_fp,
  output logic [2:0]                             out_flags
);

  localparam int unsigned W  = 2*(BFPM+2)+$clog2(V);
  localparam int unsigned E  = BIT-FPM-1;
  localparam int unsigned F  = 2*BFPM;
  localparam int unsigned KW = $clog2(W);
  // Fraction staging width: wide enough for both the zero-fill and the truncation case.
  localparam int unsigned XW = (W-1 > FPM) ? W-1 : FPM;

  localparam logic signed [E+1:0] FOFF = (E+2)'(F);
  localparam logic signed [E+1:0] EMAX = (E+2)'((1 << E) - 1);

  typedef enum logic [1:0] {StIdle, StNorm, StPack, StOut} state_e;

  state_e          state;
  logic            sign_q;
  logic [W-1:0]    mag_q;
  logic [KW-1:0]   k_q;
  logic [E-1:0]    exp_q;

  // Pack-stage combinational result
  logic [XW-1:0]          ext;
  logic [FPM-1:0]         frac;
  logic [FPM-1:0]         frac_r;
  logic signed [E+1:0]    e_c;
  logic signed [E+1:0]    e_r;
  logic [BIT-1:0]         pack_fp;
  logic [2:0]             pack_flags;

`ifdef BFP2FP_RNE_EN
  logic [XW+1:0]  ext2;
  logic           guard;
  logic           sticky;
  logic           rnd;
  logic           carry;
`endif

  always_comb begin
    // Left-align the bits below the leading one into the fraction field.
    ext  = XW'(mag_q[W-2:0]) << (XW - (W-1));
    frac = ext[XW-1 -: FPM];
    e_c  = $signed({2'b00, exp_q}) + $signed((E+2)'(k_q)) - FOFF;
`ifdef BFP2FP_RNE_EN
    // Two zero guard bits keep the indices legal when nothing is dropped.
    ext2   = {ext, 2'b00};
    guard  = ext2[XW+1-FPM];
    sticky = |ext2[XW-FPM:0];
    rnd    = guard & (sticky | frac[0]);
    {carry, frac_r} = {1'b0, frac} + (FPM+1)'(rnd);
    e_r    = e_c + (E+2)'(carry);
`else
    frac_r = frac;
    e_r    = e_c;
`endif
    pack_fp    = '0;
    pack_flags = 3'b000;
    if (mag_q == '0) begin
      pack_flags = 3'b001;
    end else if (e_r <= 0) begin
      // No denormals: flush to signed zero.
      pack_fp    = {sign_q, {(BIT-1){1'b0}}};
      pack_flags = 3'b010;
    end else if (e_r >= EMAX) begin
      pack_fp    = {sign_q, {E{1'b1}}, {FPM{1'b0}}};
      pack_flags = 3'b100;
    end else begin
      pack_fp    = {sign_q, e_r[E-1:0], frac_r};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_fp    <= '0;
      out_flags <= '0;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      k_q       <= '0;
      exp_q     <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid && in_ready) begin
            sign_q   <= in_val[W-1];
            // Most negative input wraps to 2^(W-1), which is still the right magnitude.
            mag_q    <= in_val[W-1] ? W'(-in_val) : in_val;
            k_q      <= KW'(W-1);
            exp_q    <= in_exp;
            in_ready <= 1'b0;
            state    <= (in_val == '0) ? StPack : StNorm;
          end
        end
        StNorm: begin
          if (mag_q[W-1]) begin
            state <= StPack;
          end else begin
            mag_q <= mag_q << 1;
            k_q   <= k_q - KW'(1);
          end
        end
        StPack: begin
          out_fp    <= pack_fp;
          out_flags <= pack_flags;
          out_valid <= 1'b1;
          state     <= StOut;
        end
        StOut: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bfp_to_fp.sv
module tb_bfp_to_fp;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [14:0] in_val;
  logic [7:0]  in_exp;
  logic [31:0] out_fp;
  logic [2:0]  out_flags;

  // Wide instance (BFPM=12, W=31) for the rounding cases
  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  logic [30:0] in_val1;
  logic [7:0]  in_exp1;
  logic [31:0] out_fp1;
  logic [2:0]  out_flags1;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef BFP2FP_RNE_EN
  localparam logic [31:0] RndExp = 32'h3F80_0002;
`else
  localparam logic [31:0] RndExp = 32'h3F80_0001;
`endif

  always #5 clk = ~clk;

  bfp_to_fp dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_val    (in_val),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_fp    (out_fp),
    .out_flags (out_flags)
  );

  bfp_to_fp #(.BFPM(12)) dut_wide (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_val    (in_val1),
    .in_exp    (in_exp1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_fp    (out_fp1),
    .out_flags (out_flags1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Full transaction on the default instance: accept, measure latency, check, handshake.
  task automatic convert(input string tag, input logic [14:0] v, input logic [7:0] x,
                         input logic [31:0] efp, input logic [2:0] efl, input int elat);
    int lat;
    @(negedge clk);
    in_val = v; in_exp = x; in_valid = 1'b1; out_ready = 1'b0;
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_val = 15'h1555; in_exp = 8'hAA;  // later changes must be ignored
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_fp"}, out_fp, efp);
    check({tag, "_flg"}, 32'(out_flags), 32'(efl));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ovd"}, 32'(out_valid), 32'd0);
    check({tag, "_ird"}, 32'(in_ready), 32'd1);
  endtask

  task automatic convert_wide(input string tag, input logic [30:0] v, input logic [31:0] efp);
    int lat;
    @(negedge clk);
    in_val1 = v; in_exp1 = 8'd127; in_valid1 = 1'b1; out_ready1 = 1'b0;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd8);
    check({tag, "_fp"}, out_fp1, efp);
    @(negedge clk);
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; in_val = '0; in_exp = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; in_val1 = '0; in_exp1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ird", 32'(in_ready), 32'd1);
    check("rst_ovd", 32'(out_valid), 32'd0);
    check("rst_fp", out_fp, 32'd0);
    check("rst_flg", 32'(out_flags), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Basic, zero, most negative, range limits
    convert("one",    15'h0100, 8'd127, 32'h3F80_0000, 3'b000, 8);
    convert("m384",   15'h7E80, 8'd128, 32'hC040_0000, 3'b000, 8);
    convert("zero",   15'h0000, 8'd77,  32'h0000_0000, 3'b001, 1);
    convert("mneg",   15'h4000, 8'd127, 32'hC280_0000, 3'b000, 2);
    convert("ovf",    15'h3FFF, 8'd250, 32'h7F80_0000, 3'b100, 3);
    convert("unfp",   15'h0001, 8'd5,   32'h0000_0000, 3'b010, 16);
    convert("unfn",   15'h7FFF, 8'd5,   32'h8000_0000, 3'b010, 16);

    // Backpressure: result held, in_ready low, new in_valid ignored
    @(negedge clk);
    in_val = 15'h0100; in_exp = 8'd127; in_valid = 1'b1;
    @(posedge clk); #1;
    in_val = 15'h0003; in_exp = 8'd3;   // presented while busy; must not be taken
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_lat", 32'(lat), 32'd8);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_fp", out_fp, 32'h3F80_0000);
      check("bp_flg", 32'(out_flags), 32'd0);
      check("bp_ird", 32'(in_ready), 32'd0);
      check("bp_ovd", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    in_val = 15'h7E80; in_exp = 8'd128;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_hs_ovd", 32'(out_valid), 32'd0);
    check("bp_hs_ird", 32'(in_ready), 32'd1);
    @(posedge clk); #1;          // accept edge for the waiting input
    in_valid = 1'b0;
    check("bp_acc_ird", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp2_lat", 32'(lat), 32'd8);
    check("bp2_fp", out_fp, 32'hC040_0000);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during normalisation
    @(negedge clk);
    in_val = 15'h0001; in_exp = 8'd127; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rstn_ovd", 32'(out_valid), 32'd0);
    check("rstn_ird", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("rstn_stale", 32'(out_valid), 32'd0);
    convert("postrst", 15'h0100, 8'd127, 32'h3F80_0000, 3'b000, 8);

    // Rounding on the wide instance
    convert_wide("rnd_tie", 31'h0100_0001, 32'h3F80_0000);
    convert_wide("rnd_up",  31'h0100_0003, RndExp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
